afifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of the async FIFO among

---
 rtl/afifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter for the async FIFO write port; one write per two cycles.
// Optional stall counter enabled by defining AFIFO_ARB_STATS_EN.
module afifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic                   i_wr_clk,
    input  logic                   i_wr_rst,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*DSIZE-1:0]  i_req_data,
    input  logic                   i_wr_full,
    output logic [NREQ-1:0]        o_gnt,
    output logic [DSIZE-1:0]       o_wr_data,
    output logic                   o_wr_inc,
    output logic                   o_busy
`ifdef AFIFO_ARB_STATS_EN
    ,
    output logic [CNTW-1:0]        o_stall_cnt
`endif
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    logic [LW-1:0]     r_last;
    logic [NREQ-1:0]   r_gnt;
    logic [DSIZE-1:0]  r_wr_data;
    logic              r_wr_inc;
    logic              r_busy;

    logic              w_found;
    logic [LW-1:0]     w_win;
    logic [NREQ-1:0]   w_gnt;
    logic [DSIZE-1:0]  w_win_dat;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [LW-1:0] v_idx;
        w_found = 1'b0;
        w_win   = r_last;
        v_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = LW'((int'(r_last) + k) % NREQ);
            if (!w_found && i_req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_comb begin
        w_gnt        = '0;
        w_gnt[w_win] = w_found;
        w_win_dat    = i_req_data[w_win*DSIZE +: DSIZE];
    end

    // ISSUE is a mandatory gap so the next decision sees the updated full flag.
    always_ff @(posedge i_wr_clk) begin
        if (i_wr_rst) begin
            r_state   <= IDLE;
            r_last    <= LW'(NREQ - 1);
            r_gnt     <= '0;
            r_wr_data <= '0;
            r_wr_inc  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found && !i_wr_full) begin
                        r_state   <= ISSUE;
                        r_last    <= w_win;
                        r_gnt     <= w_gnt;
                        r_wr_data <= w_win_dat;
                        r_wr_inc  <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state  <= IDLE;
                    r_gnt    <= '0;
                    r_wr_inc <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_gnt    <= '0;
                    r_wr_inc <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_wr_data = r_wr_data;
    assign o_wr_inc  = r_wr_inc;
    assign o_busy    = r_busy;

`ifdef AFIFO_ARB_STATS_EN
    logic [CNTW-1:0] r_stall_cnt;

    // Saturating count of cycles a pending request is held off by a full FIFO.
    always_ff @(posedge i_wr_clk) begin
        if (i_wr_rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && (|i_req) && i_wr_full && (r_stall_cnt != {CNTW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    if (CNTW < 1) begin : g_bad_cntw
        $error("CNTW must be at least 1");
    end
`endif

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter with a depth-8 FIFO occupancy model.
module tb_afifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int CNTW  = 16;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wr_full;
    logic [NREQ-1:0]       gnt;
    logic [DSIZE-1:0]      wr_data;
    logic                  wr_inc;
    logic                  busy;
`ifdef AFIFO_ARB_STATS_EN
    logic [CNTW-1:0]       stall_cnt;
`endif

    int   fifo_cnt;
    logic drain;
    logic force_full;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_wr;
    int   n_g1;

    always #5 clk = ~clk;

    afifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .i_wr_clk   (clk),
        .i_wr_rst   (rst),
        .i_req      (req),
        .i_req_data (req_data),
        .i_wr_full  (wr_full),
        .o_gnt      (gnt),
        .o_wr_data  (wr_data),
        .o_wr_inc   (wr_inc),
        .o_busy     (busy)
`ifdef AFIFO_ARB_STATS_EN
        ,
        .o_stall_cnt(stall_cnt)
`endif
    );

    assign wr_full = force_full || (fifo_cnt >= DEPTH);

    always @(posedge clk) begin
        if (rst)
            fifo_cnt <= 0;
        else
            fifo_cnt <= fifo_cnt + (wr_inc ? 1 : 0) - ((drain && fifo_cnt > 0) ? 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        drain      = 1'b0;
        force_full = 1'b0;
        req_data   = {8'h44, 8'h33, 8'h22, 8'hA5};

        // 1: reset overrides requests; first grant goes to requester 0
        req = 4'b1111;
        step();
        check("t1_rst_gnt0", 32'(gnt), 32'h0);
        check("t1_rst_inc0", 32'(wr_inc), 32'h0);
        check("t1_rst_dat0", 32'(wr_data), 32'h0);
        check("t1_rst_busy0", 32'(busy), 32'h0);
        step();
        check("t1_rst_gnt1", 32'(gnt), 32'h0);
        check("t1_rst_inc1", 32'(wr_inc), 32'h0);
        rst = 1'b0;
        step();
        check("t1_first_gnt", 32'(gnt), 32'h1);
        check("t1_first_inc", 32'(wr_inc), 32'h1);
        check("t1_first_dat", 32'(wr_data), 32'hA5);
        check("t1_first_busy", 32'(busy), 32'h1);
        req = '0;
        step();
        check("t1_after_gnt", 32'(gnt), 32'h0);
        check("t1_after_inc", 32'(wr_inc), 32'h0);
        check("t1_after_busy", 32'(busy), 32'h0);
        step();
        check("t1_hold_dat", 32'(wr_data), 32'hA5);

        // 2: single requester fills the FIFO, then writes stop
        do_reset();
        req  = 4'b0001;
        n_wr = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (wr_inc) n_wr++;
            check($sformatf("t2_inc_%0d", k), 32'(wr_inc), ((k % 2 == 1) && (k <= 15)) ? 32'h1 : 32'h0);
            if ((k % 2 == 1) && (k <= 15))
                check($sformatf("t2_dat_%0d", k), 32'(wr_data), 32'hA5);
        end
        check("t2_writes", 32'(n_wr), 32'd8);
        check("t2_full", 32'(wr_full), 32'h1);

        // 3: all requesting with a drained FIFO rotates the grant
        do_reset();
        drain = 1'b1;
        req   = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            step();
            case (k)
                1, 9:    check($sformatf("t3_gnt_%0d", k), 32'(gnt), 32'h1);
                3:       check("t3_gnt_3", 32'(gnt), 32'h2);
                5:       check("t3_gnt_5", 32'(gnt), 32'h4);
                7:       check("t3_gnt_7", 32'(gnt), 32'h8);
                default: check($sformatf("t3_gap_%0d", k), 32'(gnt), 32'h0);
            endcase
            if (k == 5) check("t3_dat_5", 32'(wr_data), 32'h33);
            if (k == 7) check("t3_dat_7", 32'(wr_data), 32'h44);
        end

        // 4: full FIFO blocks the grant until it clears
        do_reset();
        force_full = 1'b1;
        req        = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t4_blk_gnt_%0d", k), 32'(gnt), 32'h0);
            check($sformatf("t4_blk_inc_%0d", k), 32'(wr_inc), 32'h0);
        end
`ifdef AFIFO_ARB_STATS_EN
        check("t4_stall", 32'(stall_cnt), 32'd5);
`endif
        force_full = 1'b0;
        step();
        check("t4_gnt", 32'(gnt), 32'h4);
        check("t4_dat", 32'(wr_data), 32'h33);
        req = '0;
        drain = 1'b1;
        step();

        // 5: reset in ISSUE aborts and restores the pointer
        do_reset();
        req = 4'b0100;
        step();
        check("t5_issue_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        req = 4'b0101;
        step();
        check("t5_abort_inc", 32'(wr_inc), 32'h0);
        check("t5_abort_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        step();
        check("t5_next_gnt", 32'(gnt), 32'h1);
        req = 4'b1010;
        step();
        step();
        check("t5_rr_gnt", 32'(gnt), 32'h2);

        // 6: request seen only during ISSUE is never granted
        do_reset();
        req = 4'b0001;
        step();
        check("t6_gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        step();
        req  = '0;
        n_g1 = 0;
        n_wr = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (gnt[1]) n_g1++;
            if (wr_inc) n_wr++;
        end
        check("t6_no_gnt1", 32'(n_g1), 32'd0);
        check("t6_no_inc", 32'(n_wr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
